// File: rtl/midi_msg_assemble.sv
// Assembles MIDI channel voice messages from a UART byte stream. It handles running
// status, ignores real-time bytes and skips SysEx blocks.
module midi_msg_assemble #(
  parameter bit          VEL0_IS_OFF = 1'b1,
  parameter int unsigned ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             midi_command_ready,
  output logic [3:0]       ch_message,
  output logic [3:0]       chan,
  output logic [6:0]       note,
  output logic [6:0]       velocity,
  output logic [6:0]       lsb,
  output logic [6:0]       msb,
  output logic             sysex_active,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned DATA_W   = 7;
  localparam logic [3:0]  MSG_OFF  = 4'h8;
  localparam logic [3:0]  MSG_ON   = 4'h9;
  localparam logic [3:0]  MSG_PROG = 4'hC;
  localparam logic [3:0]  MSG_PRES = 4'hD;

  typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2, SYSEX} state_t;

  state_t            state, state_n;
  logic [3:0]        rs_msg, rs_msg_n;
  logic [3:0]        rs_chan, rs_chan_n;
  logic [DATA_W-1:0] d1, d1_n;
  logic              err_inc;

  // Completed message staged one cycle before it reaches the outputs
  logic              pend_valid, pend_valid_n;
  logic [3:0]        pend_msg, pend_msg_n;
  logic [3:0]        pend_chan, pend_chan_n;
  logic [DATA_W-1:0] pend_d1, pend_d1_n;
  logic [DATA_W-1:0] pend_d2, pend_d2_n;

  logic is_rt, is_chan, is_sys, is_data, needs_two;

  always_comb begin
    is_data   = ~byte_in[7];
    is_rt     = byte_in[7:3] == 5'b11111;
    is_sys    = byte_in[7:3] == 5'b11110;
    is_chan   = byte_in[7] && (byte_in[7:4] != 4'hF);
    needs_two = (rs_msg != MSG_PROG) && (rs_msg != MSG_PRES);
  end

  // Byte classification, running status and message completion
  always_comb begin
    state_n      = state;
    rs_msg_n     = rs_msg;
    rs_chan_n    = rs_chan;
    d1_n         = d1;
    err_inc      = 1'b0;
    pend_valid_n = 1'b0;
    pend_msg_n   = rs_msg;
    pend_chan_n  = rs_chan;
    pend_d1_n    = d1;
    pend_d2_n    = '0;

    if (byte_valid && !is_rt) begin
      if (is_chan || is_sys) begin
        // Any status byte abandons a half-received two-byte message
        err_inc = (state == WAIT_D2);
        if (is_chan) begin
          rs_msg_n  = byte_in[7:4];
          rs_chan_n = byte_in[3:0];
          state_n   = WAIT_D1;
        end else begin
          rs_msg_n  = '0;
          rs_chan_n = '0;
          state_n   = (byte_in == 8'hF0) ? SYSEX : IDLE;
        end
      end else if (is_data) begin
        unique case (state)
          IDLE:  err_inc = 1'b1;
          SYSEX: err_inc = 1'b0;
          WAIT_D1: begin
            d1_n = byte_in[6:0];
            if (needs_two) begin
              state_n = WAIT_D2;
            end else begin
              pend_valid_n = 1'b1;
              pend_d1_n    = byte_in[6:0];
            end
          end
          WAIT_D2: begin
            state_n      = WAIT_D1;
            pend_valid_n = 1'b1;
            pend_d2_n    = byte_in[6:0];
          end
          default: state_n = IDLE;
        endcase
      end
    end

    if (VEL0_IS_OFF && pend_msg_n == MSG_ON && pend_d2_n == '0) begin
      pend_msg_n = MSG_OFF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rs_msg       <= '0;
      rs_chan      <= '0;
      d1           <= '0;
      sysex_active <= 1'b0;
      err_count    <= '0;
      pend_valid   <= 1'b0;
      pend_msg     <= '0;
      pend_chan    <= '0;
      pend_d1      <= '0;
      pend_d2      <= '0;
    end else begin
      state        <= state_n;
      rs_msg       <= rs_msg_n;
      rs_chan      <= rs_chan_n;
      d1           <= d1_n;
      sysex_active <= (state_n == SYSEX);
      if (err_inc && (err_count != {ERR_W{1'b1}})) begin
        err_count <= err_count + ERR_W'(1);
      end
      pend_valid <= pend_valid_n;
      if (pend_valid_n) begin
        pend_msg  <= pend_msg_n;
        pend_chan <= pend_chan_n;
        pend_d1   <= pend_d1_n;
        pend_d2   <= pend_d2_n;
      end
    end
  end

  // Output stage: fields hold until the next completed message
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      midi_command_ready <= 1'b0;
      ch_message         <= '0;
      chan               <= '0;
      note               <= '0;
      velocity           <= '0;
      lsb                <= '0;
      msb                <= '0;
    end else begin
      midi_command_ready <= pend_valid;
      if (pend_valid) begin
        ch_message <= pend_msg;
        chan       <= pend_chan;
        note       <= pend_d1;
        velocity   <= pend_d2;
        lsb        <= pend_d1;
        msb        <= pend_d2;
      end
    end
  end

endmodule

// File: tb/tb_midi_msg_assemble.sv
// Self-checking bench for midi_msg_assemble. Each expected message is queued when its final byte is
// driven, and it is compared when the ready pulse is seen.
module tb_midi_msg_assemble;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       midi_command_ready;
  logic [3:0] ch_message, chan;
  logic [6:0] note, velocity, lsb, msb;
  logic       sysex_active;
  logic [7:0] err_count;

  typedef struct packed {
    logic [3:0] msg;
    logic [3:0] ch;
    logic [6:0] d1;
    logic [6:0] d2;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  midi_msg_assemble dut (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
    .midi_command_ready(midi_command_ready), .ch_message(ch_message), .chan(chan),
    .note(note), .velocity(velocity), .lsb(lsb), .msb(msb),
    .sysex_active(sysex_active), .err_count(err_count)
  );

  always #10 clk = ~clk;

  // Scoreboard: every ready pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (!rst && midi_command_ready === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_pulse: got msg=%h ch=%h note=%h vel=%h, required no pulse",
                 ch_message, chan, note, velocity);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({ch_message, chan, note, velocity, lsb, msb} !== {e.msg, e.ch, e.d1, e.d2, e.d1, e.d2}) begin
          miscompares++;
          $display("FAIL message: got msg=%h ch=%h note=%h vel=%h lsb=%h msb=%h, required msg=%h ch=%h d1=%h d2=%h",
                   ch_message, chan, note, velocity, lsb, msb, e.msg, e.ch, e.d1, e.d2);
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_msg(input logic [3:0] m, input logic [3:0] c,
                            input logic [6:0] a, input logic [6:0] b);
    exp_t e;
    e = '{msg: m, ch: c, d1: a, d2: b};
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    byte_valid = 1'b0;
    byte_in = 8'h00;
    idle(2);
    rst = 1'b0;
    idle(1);
  endtask

  task automatic check_err(input string name, input logic [7:0] want);
    vectors++;
    if (err_count !== want) begin
      miscompares++;
      $display("FAIL %s err_count: got %h, required %h", name, err_count, want);
    end
  endtask

  task automatic check_sysex(input string name, input logic want);
    vectors++;
    if (sysex_active !== want) begin
      miscompares++;
      $display("FAIL %s sysex_active: got %b, required %b", name, sysex_active, want);
    end
  endtask

  task automatic check_drained(input string name);
    idle(3);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s missing_pulses: got %0d outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_outputs_zero(input string name);
    vectors++;
    if ({midi_command_ready, ch_message, chan, note, velocity, lsb, msb, sysex_active} !== '0) begin
      miscompares++;
      $display("FAIL %s outputs: got rdy=%b msg=%h ch=%h note=%h vel=%h lsb=%h msb=%h sx=%b, required all 0",
               name, midi_command_ready, ch_message, chan, note, velocity, lsb, msb, sysex_active);
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_outputs_zero("reset");
    check_err("reset", 8'h00);
  endtask

  task automatic test_note_on();
    do_reset();
    send(8'h90); send(8'h3C);
    expect_msg(4'h9, 4'h0, 7'h3C, 7'h64);
    send(8'h64);
    check_drained("note_on");
    check_err("note_on", 8'h00);
  endtask

  // Back-to-back bytes; the 3E arrives in the same cycle as the first pulse
  task automatic test_back_to_back();
    do_reset();
    send(8'h93); send(8'h3C);
    expect_msg(4'h9, 4'h3, 7'h3C, 7'h64);
    send(8'h64); send(8'h3E);
    expect_msg(4'h8, 4'h3, 7'h3E, 7'h00);
    send(8'h00);
    check_drained("running_status");
    check_err("running_status", 8'h00);
  endtask

  task automatic test_realtime();
    do_reset();
    send(8'hB1); send(8'hF8); send(8'h07); send(8'hFE);
    expect_msg(4'hB, 4'h1, 7'h07, 7'h7F);
    send(8'h7F);
    check_drained("realtime");
    check_err("realtime", 8'h00);
  endtask

  task automatic test_sysex();
    do_reset();
    send(8'hF0);
    check_sysex("sysex_start", 1'b1);
    send(8'h43); send(8'h12);
    check_sysex("sysex_body", 1'b1);
    send(8'hF7);
    check_sysex("sysex_end", 1'b0);
    send(8'h25);
    check_drained("sysex");
    check_err("sysex_stray", 8'h01);
    send(8'hC2);
    expect_msg(4'hC, 4'h2, 7'h05, 7'h00);
    send(8'h05);
    expect_msg(4'hC, 4'h2, 7'h05, 7'h00);
    send(8'h05);
    check_drained("prog_change");
    check_err("prog_change", 8'h01);
  endtask

  task automatic test_abort();
    do_reset();
    send(8'h90); send(8'h3C); send(8'hE0); send(8'h00);
    expect_msg(4'hE, 4'h0, 7'h00, 7'h40);
    send(8'h40);
    check_drained("abort");
    check_err("abort", 8'h01);
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 300; i++) send(8'h05);
    idle(2);
    check_err("saturate", 8'hFF);
    check_drained("saturate");
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(8'h90); send(8'h3C);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(1);
    send(8'h64);
    idle(3);
    check_outputs_zero("reset_mid");
    check_err("reset_mid", 8'h01);
    check_drained("reset_mid");
  endtask

  initial begin
    rst = 1'b1;
    byte_valid = 1'b0;
    byte_in = 8'h00;
    @(negedge clk);
    test_reset();
    test_note_on();
    test_back_to_back();
    test_realtime();
    test_sysex();
    test_abort();
    test_saturate();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
